fir_stream_source: RTL and testbench

Stream transmitter that feeds the pipelined FIR's sample input. Producer logic pushes samples through a simple write port into an internal FIFO. The block emits them on an AXI-Stream-style master port wired to the FIR's `s_axis_fir_*` slave inputs, and frames them with `tlast` every `FRAME_LEN` beats or on request.

---
 rtl/fir_stream_source.sv | 159 +++++++++++++++
 tb/tb_fir_stream_source.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/fir_stream_source.sv
// ============================================================================
// fir_stream_source : FIFO-buffered AXI-Stream sample source for the FIR,
//                     framed with tlast every FRAME_LEN beats or on flush.
// Optional feature  : FIR_SRC_OVERFLOW_EN (sticky overflow detection)
// Revision          : 1.0
// ============================================================================
`default_nettype none

module fir_stream_source #(
  parameter int DATA_WIDTH = 16,
  parameter int FIFO_DEPTH = 16,
  parameter int FRAME_LEN  = 64
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  wr_en,
  output logic                  full,
  input  logic                  flush,
  output logic [DATA_WIDTH-1:0] m_axis_fir_tdata,
  output logic                  m_axis_fir_tvalid,
  input  logic                  m_axis_fir_tready,
  output logic                  m_axis_fir_tlast,
  output logic                  overflow
);

  localparam int c_AW = $clog2(FIFO_DEPTH);
  localparam int c_CW = $clog2(FRAME_LEN);
  localparam logic [c_CW-1:0] c_LAST_POS = c_CW'(FRAME_LEN - 1);
  localparam logic [c_AW:0]   c_ONE      = (c_AW + 1)'(1);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_SEND = 1'b1
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [DATA_WIDTH-1:0] r_mem [FIFO_DEPTH];
  logic [c_AW:0]         r_wr_ptr;
  logic [c_AW:0]         r_rd_ptr;
  logic [c_AW:0]         w_count;
  logic                  w_full;
  logic                  w_empty;
  logic                  w_wr_acc;
  logic                  w_xfer;
  logic                  w_load;
  logic [DATA_WIDTH-1:0] r_data;
  logic                  r_last;
  logic [c_CW-1:0]       r_beat_cnt;
  logic [c_CW-1:0]       w_next_pos;
  logic                  w_nat_last;
  logic                  w_flush_last;
  logic                  w_load_last;
  logic                  r_flush_pending;

  assign w_count  = r_wr_ptr - r_rd_ptr;
  assign w_empty  = (r_wr_ptr == r_rd_ptr);
  assign w_full   = (r_wr_ptr[c_AW] != r_rd_ptr[c_AW]) &&
                    (r_wr_ptr[c_AW-1:0] == r_rd_ptr[c_AW-1:0]);
  assign w_wr_acc = wr_en && !w_full;
  assign w_xfer   = (r_state == S_SEND) && m_axis_fir_tready;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!w_empty) begin
          w_state_nxt = S_SEND;
          w_load      = 1'b1;
        end
      end
      S_SEND: begin
        if (w_xfer) begin
          if (w_empty) w_state_nxt = S_IDLE;
          else         w_load      = 1'b1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Frame position of the beat being loaded: a beat leaving this cycle
  // has already advanced (or closed) the frame.
  assign w_next_pos   = w_xfer ? (r_last ? '0 : r_beat_cnt + c_CW'(1)) : r_beat_cnt;
  assign w_nat_last   = (w_next_pos == c_LAST_POS);
  assign w_flush_last = r_flush_pending && (w_count == c_ONE) && !w_wr_acc;
  assign w_load_last  = w_nat_last || w_flush_last;

  always_ff @(posedge clk) begin
    if (w_wr_acc) r_mem[r_wr_ptr[c_AW-1:0]] <= wr_data;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_wr_acc) r_wr_ptr <= r_wr_ptr + c_ONE;
      if (w_load)   r_rd_ptr <= r_rd_ptr + c_ONE;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_data <= '0;
      r_last <= 1'b0;
    end else if (w_load) begin
      r_data <= r_mem[r_rd_ptr[c_AW-1:0]];
      r_last <= w_load_last;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_beat_cnt <= '0;
    end else if (w_xfer) begin
      r_beat_cnt <= r_last ? '0 : r_beat_cnt + c_CW'(1);
    end
  end

  // A flush arriving while nothing is buffered has no frame to close.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_flush_pending <= 1'b0;
    end else if (w_load && w_load_last) begin
      r_flush_pending <= 1'b0;
    end else if (flush && !(w_empty && (r_state == S_IDLE))) begin
      r_flush_pending <= 1'b1;
    end
  end

`ifdef FIR_SRC_OVERFLOW_EN
  logic r_overflow;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)              r_overflow <= 1'b0;
    else if (wr_en && w_full)  r_overflow <= 1'b1;
  end

  assign overflow = r_overflow;
`else
  assign overflow = 1'b0;
`endif

  assign full              = w_full;
  assign m_axis_fir_tvalid = (r_state == S_SEND);
  assign m_axis_fir_tdata  = r_data;
  assign m_axis_fir_tlast  = r_last;

endmodule

`default_nettype wire

// File: tb/tb_fir_stream_source.sv
// ============================================================================
// tb_fir_stream_source : scoreboard bench for fir_stream_source (FRAME_LEN=4).
// Revision             : 1.0
// ============================================================================
`default_nettype none

module tb_fir_stream_source;

  localparam int DW = 16;
  localparam int FL = 4;
  localparam int FD = 16;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic [DW-1:0] wr_data = '0;
  logic          wr_en = 1'b0;
  logic          full;
  logic          flush = 1'b0;
  logic [DW-1:0] tdata;
  logic          tvalid;
  logic          tready = 1'b0;
  logic          tlast;
  logic          overflow;

  int n_checks = 0;
  int n_fails  = 0;

  // Expected beats: {tlast, tdata}
  logic [DW:0] q[$];

  fir_stream_source #(
    .DATA_WIDTH(DW),
    .FIFO_DEPTH(FD),
    .FRAME_LEN (FL)
  ) u_dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .wr_data          (wr_data),
    .wr_en            (wr_en),
    .full             (full),
    .flush            (flush),
    .m_axis_fir_tdata (tdata),
    .m_axis_fir_tvalid(tvalid),
    .m_axis_fir_tready(tready),
    .m_axis_fir_tlast (tlast),
    .overflow         (overflow)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (reset_n === 1'b1 && tvalid === 1'b1) begin
      if (tready) begin
        if (q.size() == 0) begin
          check_eq("unexpected_beat", {15'd0, tlast, tdata}, 32'hFFFF_FFFF);
        end else begin
          logic [DW:0] e;
          e = q.pop_front();
          check_eq("tdata", {16'd0, tdata}, {16'd0, e[DW-1:0]});
          check_eq("tlast", {31'd0, tlast}, {31'd0, e[DW]});
        end
      end else if (q.size() != 0) begin
        check_eq("hold_tdata", {16'd0, tdata}, {16'd0, q[0][DW-1:0]});
      end
    end
  end

  task automatic apply_reset();
    reset_n = 1'b0;
    wr_en   = 1'b0;
    flush   = 1'b0;
    tready  = 1'b0;
    q.delete();
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_tvalid", {31'd0, tvalid}, 32'd0);
    check_eq("rst_tdata", {16'd0, tdata}, 32'd0);
    check_eq("rst_tlast", {31'd0, tlast}, 32'd0);
    check_eq("rst_full", {31'd0, full}, 32'd0);
    check_eq("rst_overflow", {31'd0, overflow}, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [DW-1:0] d, input logic last, input bit push);
    wr_en   = 1'b1;
    wr_data = d;
    if (push) q.push_back({last, d});
    @(posedge clk);
    #1;
    wr_en = 1'b0;
  endtask

  task automatic pulse_flush();
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
  endtask

  task automatic wait_drain(input string tag);
    for (int i = 0; i < 200 && q.size() != 0; i++) begin
      @(posedge clk);
      #1;
    end
    @(posedge clk);
    #1;
    check_eq({tag, "_drained"}, q.size(), 32'd0);
    check_eq({tag, "_idle"}, {31'd0, tvalid}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog_timeout got=running exp=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    // Basic stream and write-to-valid latency
    apply_reset();
    tready = 1'b1;
    do_write(16'd1, 1'b0, 1'b1);
    check_eq("lat_not_yet", {31'd0, tvalid}, 32'd0);
    do_write(16'd2, 1'b0, 1'b1);
    check_eq("lat_valid", {31'd0, tvalid}, 32'd1);
    do_write(16'd3, 1'b0, 1'b1);
    check_eq("b2b_valid2", {31'd0, tvalid}, 32'd1);
    @(posedge clk);
    #1;
    check_eq("b2b_valid3", {31'd0, tvalid}, 32'd1);
    wait_drain("basic");

    // Natural framing: tlast on beats 4, 8, 12
    apply_reset();
    tready = 1'b1;
    for (int i = 0; i < 12; i++)
      do_write(16'h8000 + 16'(i * 37), ((i % FL) == FL - 1), 1'b1);
    wait_drain("frame");

    // Stall until full, overflow, then drain in order
    apply_reset();
    for (int i = 0; i < FD + 2; i++) begin
      do_write(16'hA000 + 16'(i), ((i % FL) == FL - 1), (i < FD + 1));
      if (i == FD - 1) begin
        check_eq("not_full_yet", {31'd0, full}, 32'd0);
      end
      if (i == FD) begin
        check_eq("full_set", {31'd0, full}, 32'd1);
        check_eq("ovf_before", {31'd0, overflow}, 32'd0);
      end
    end
    check_eq("full_still", {31'd0, full}, 32'd1);
`ifdef FIR_SRC_OVERFLOW_EN
    check_eq("overflow", {31'd0, overflow}, 32'd1);
`else
    check_eq("overflow", {31'd0, overflow}, 32'd0);
`endif
    tready = 1'b1;
    @(posedge clk);
    #1;
    tready = 1'b0;
    check_eq("full_freed", {31'd0, full}, 32'd0);
    repeat (3) @(posedge clk);
    #1;
    tready = 1'b1;
    wait_drain("stall");

    // Early flush closes frame on beat 3; next frame starts from zero
    apply_reset();
    do_write(16'hF001, 1'b0, 1'b1);
    do_write(16'hF002, 1'b0, 1'b1);
    do_write(16'hF003, 1'b1, 1'b1);
    pulse_flush();
    tready = 1'b1;
    wait_drain("flush");
    for (int i = 0; i < FL; i++)
      do_write(16'h0100 + 16'(i), (i == FL - 1), 1'b1);
    wait_drain("after_flush");

    // Flush on an idle block is ignored
    apply_reset();
    tready = 1'b1;
    pulse_flush();
    do_write(16'h7FFF, 1'b0, 1'b1);
    wait_drain("idle_flush");
    for (int i = 1; i < FL; i++)
      do_write(16'h0200 + 16'(i), (i == FL - 1), 1'b1);
    wait_drain("idle_flush_frame");

    // Reset mid-frame with a held beat
    apply_reset();
    do_write(16'hC001, 1'b0, 1'b1);
    do_write(16'hC002, 1'b0, 1'b1);
    do_write(16'hC003, 1'b0, 1'b1);
    tready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    tready = 1'b0;
    check_eq("pre_rst_valid", {31'd0, tvalid}, 32'd1);
    #3;
    reset_n = 1'b0;
    q.delete();
    #1;
    check_eq("async_rst_valid", {31'd0, tvalid}, 32'd0);
    check_eq("async_rst_data", {16'd0, tdata}, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    tready = 1'b1;
    for (int i = 0; i < FL; i++)
      do_write(16'hD000 + 16'(i), (i == FL - 1), 1'b1);
    wait_drain("post_rst");

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fails);
    $finish;
  end

endmodule

`default_nettype wire
